prog_clock_generator: RTL and testbench

Parametrised successor to the fixed decade clock generator. It provides CHANNELS independent clock-enable generators from the single system clock `clk` (50 MHz on the MAX1000 board). Each channel's divisor is programmable at run time, and each channel produces a one-cycle `tick` strobe and a `square` output. Divisor changes are glitch-free through per-channel shadow registers. A common `sync` input phase-aligns all channels, for example for the motion-control sample clock and display multiplexing.

---
 rtl/clock_gen_pkg.sv | 24 ++
 rtl/clock_gen_channel.sv | 84 ++++++++
 rtl/prog_clock_generator.sv | 50 +++++
 tb/tb_prog_clock_generator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clock_gen_pkg.sv
// Shared constants and types for the programmable clock-enable generator.
package clock_gen_pkg;

  // Divisor width large enough for 1 Hz from a 50 MHz system clock.
  localparam int DEF_DIV_W = 26;

  // Divisors for common rates at 50 MHz.
  localparam int DIV_5MHZ   = 10;
  localparam int DIV_1MHZ   = 50;
  localparam int DIV_100KHZ = 500;
  localparam int DIV_10KHZ  = 5_000;
  localparam int DIV_1KHZ   = 50_000;
  localparam int DIV_100HZ  = 500_000;
  localparam int DIV_10HZ   = 5_000_000;
  localparam int DIV_1HZ    = 50_000_000;

  // Registered outputs of one channel.
  typedef struct packed {
    logic tick;
    logic square;
    logic pending;
  } ch_out_t;

endpackage

// File: rtl/clock_gen_channel.sv
// One clock-enable channel: down-counter, shadow divisor, tick and square.
module clock_gen_channel
  import clock_gen_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DIV_1MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  input  logic             sync,
  input  logic             en,
  output ch_out_t          out
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] d_q, d_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] new_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;
  logic             running, reload, apply;

  // Next-state: divisor hand-over, counting and output shaping.
  always_comb begin
    running  = en && (d_q != '0);
    reload   = running && (cnt_q == '0);
    // A write in the same cycle wins over an older pending shadow.
    new_d    = wr ? wr_data : (pend_q ? shadow_q : d_q);
    // Divisor changes take effect only where no period is in flight.
    apply    = sync || !running || reload;

    d_d      = d_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (apply) begin
      d_d      = new_d;
      shadow_d = new_d;
      pend_d   = 1'b0;
    end else if (wr) begin
      shadow_d = wr_data;
      pend_d   = 1'b1;
    end

    // A zero divisor parks the counter where it is.
    if (d_d == '0)  cnt_d = cnt_q;
    else if (apply) cnt_d = d_d - ONE;
    else            cnt_d = cnt_q - ONE;

    tick_d   = reload && !sync && (d_d != '0);
    // High from the tick until the counter drops below floor(D/2).
    square_d = en && !sync && (d_d != '0) &&
               (tick_d || (square_q && (cnt_d >= (d_d >> 1))));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q      <= DEF_D;
      shadow_q <= DEF_D;
      cnt_q    <= DEF_D - ONE;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign out.tick    = tick_q;
  assign out.square  = square_q;
  assign out.pending = pend_q;

endmodule

// File: rtl/prog_clock_generator.sv
// Multi-channel programmable clock-enable generator with shared sync and write bus.
module prog_clock_generator
  import clock_gen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DIV_1MHZ,
  parameter int ADDR_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DIV_W-1:0]    wr_data,
  input  logic                sync,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] square,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] wr_ch;
  ch_out_t             ch_out [CHANNELS];

  // Address decode; out-of-range addresses select nothing.
  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_ch[i] = wr_en && (wr_addr == ADDR_W'(i));
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_gen_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr_ch[g]),
      .wr_data(wr_data),
      .sync   (sync),
      .en     (ch_enable[g]),
      .out    (ch_out[g])
    );
    assign tick[g]    = ch_out[g].tick;
    assign square[g]  = ch_out[g].square;
    assign pending[g] = ch_out[g].pending;
  end

endmodule

// File: tb/tb_prog_clock_generator.sv
// Directed bench for prog_clock_generator (4 channels, default divisor 50).
module tb_prog_clock_generator;

  localparam int CH = 4;
  localparam int DW = 26;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, wr_en, sync;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CH-1:0] ch_enable, tick, square, pending;

  int n_chk  = 0;
  int n_pass = 0;
  int n, th, sh;
  int ft [CH];

  always #5 clk = ~clk;

  prog_clock_generator #(
    .CHANNELS(CH), .DIV_W(DW), .DEFAULT_DIV(50), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sync(sync), .ch_enable(ch_enable),
    .tick(tick), .square(square), .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic write(input int a, input int dv);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(dv);
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic tick_n(input int c, input int lim, output int cnt);
    cnt = 0;
    do begin step(1); cnt++; end while (!tick[c] && cnt < lim);
  endtask

  task automatic hi_len(input int c, input int lim, output int cnt);
    cnt = 0;
    while (square[c] && cnt < lim) begin cnt++; step(1); end
  endtask

  task automatic count_hi(input int c, input int k, output int t, output int s);
    t = 0; s = 0;
    repeat (k) begin step(1); t += int'(tick[c]); s += int'(square[c]); end
  endtask

  task automatic first_ticks(input int lim);
    for (int c = 0; c < CH; c++) ft[c] = 0;
    for (int i = 1; i <= lim; i++) begin
      step(1);
      for (int c = 0; c < CH; c++) if (ft[c] == 0 && tick[c]) ft[c] = i;
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; sync = 1'b0;
    ch_enable = '1;
    step(2);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_square", 32'(square), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);

    // Reset default: period 50, square 25 high
    reset = 1'b0;
    tick_n(0, 100, n);        chk("def_first_tick", 32'(n), 32'd50);
    chk("def_all_tick", 32'(tick), 32'hF);
    chk("def_all_square", 32'(square), 32'hF);
    hi_len(0, 100, n);        chk("def_sq_high", 32'(n), 32'd25);
    tick_n(0, 100, n);        chk("def_sq_low", 32'(n), 32'd25);
    chk("def_pending", 32'(pending), 32'h0);

    // Mid-period write ch2 D=5
    step(20);
    write(2, 5);
    chk("mw_pend_set", 32'(pending), 32'h4);
    tick_n(2, 100, n);        chk("mw_apply_at_reload", 32'(n), 32'd29);
    chk("mw_all_tick", 32'(tick), 32'hF);
    chk("mw_pend_clr", 32'(pending), 32'h0);
    hi_len(2, 20, n);         chk("mw_sq_high", 32'(n), 32'd3);
    tick_n(2, 20, n);         chk("mw_sq_low", 32'(n), 32'd2);
    tick_n(2, 20, n);         chk("mw_period5", 32'(n), 32'd5);
    tick_n(0, 100, n);        chk("mw_ch0_unchanged", 32'(n), 32'd40);

    // Sync with D = 7,10,50,3 (ch2 reload coincides with sync)
    write(0, 7); write(1, 10); write(2, 50); write(3, 3);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("sync_tick0", 32'(tick), 32'h0);
    chk("sync_square0", 32'(square), 32'h0);
    chk("sync_pend0", 32'(pending), 32'h0);
    first_ticks(60);
    chk("sync_ch0", 32'(ft[0]), 32'd7);
    chk("sync_ch1", 32'(ft[1]), 32'd10);
    chk("sync_ch2", 32'(ft[2]), 32'd50);
    chk("sync_ch3", 32'(ft[3]), 32'd3);

    // Sync with a same-cycle write to ch1
    sync = 1'b1; wr_en = 1'b1; wr_addr = AW'(1); wr_data = DW'(4);
    step(1);
    sync = 1'b0; wr_en = 1'b0;
    chk("sync2_pend", 32'(pending), 32'h0);
    chk("sync2_tick0", 32'(tick), 32'h0);
    first_ticks(60);
    chk("sync2_ch0", 32'(ft[0]), 32'd7);
    chk("sync2_ch1", 32'(ft[1]), 32'd4);
    chk("sync2_ch2", 32'(ft[2]), 32'd50);
    chk("sync2_ch3", 32'(ft[3]), 32'd3);

    // D=0 stops ch0
    write(0, 0);
    chk("d0_pend", 32'(pending), 32'h1);
    step(10);
    count_hi(0, 20, th, sh);
    chk("d0_tick", 32'(th), 32'd0);
    chk("d0_square", 32'(sh), 32'd0);
    chk("d0_pend_clr", 32'(pending), 32'h0);
    // D=1 from stopped applies at once
    write(0, 1);
    chk("d1_no_pend", 32'(pending), 32'h0);
    count_hi(0, 20, th, sh);
    chk("d1_tick", 32'(th), 32'd20);
    chk("d1_square", 32'(sh), 32'd20);
    // Out-of-range address
    write(5, 9);
    chk("oor_pend", 32'(pending), 32'h0);
    count_hi(0, 10, th, sh);
    chk("oor_ch0_tick", 32'(th), 32'd10);
    chk("oor_ch0_square", 32'(sh), 32'd10);

    // Enable drop on ch3 (D=3)
    tick_n(3, 10, n);
    tick_n(3, 10, n);         chk("en_period3", 32'(n), 32'd3);
    step(1);
    chk("en_sq_before", 32'(square[3]), 32'd1);
    ch_enable[3] = 1'b0;
    step(1);
    chk("en_off_tick", 32'(tick[3]), 32'd0);
    chk("en_off_square", 32'(square[3]), 32'd0);
    count_hi(3, 5, th, sh);
    chk("en_off_hold", 32'(th + sh), 32'd0);
    ch_enable[3] = 1'b1;
    tick_n(3, 10, n);         chk("en_first_tick", 32'(n), 32'd3);

    // Bypass: write ch1 D=6 on its reload cycle
    tick_n(1, 10, n);
    step(3);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = DW'(6);
    step(1);
    wr_en = 1'b0;
    chk("byp_tick", 32'(tick[1]), 32'd1);
    chk("byp_pend", 32'(pending[1]), 32'd0);
    hi_len(1, 20, n);         chk("byp_sq_high", 32'(n), 32'd3);
    chk("byp_pend_later", 32'(pending[1]), 32'd0);
    tick_n(1, 20, n);         chk("byp_sq_low", 32'(n), 32'd3);

    // Reset mid-operation with a pending write
    tick_n(2, 100, n);
    write(2, 20);
    chk("rm_pend_set", 32'(pending[2]), 32'd1);
    reset = 1'b1;
    step(1);
    chk("rm_tick", 32'(tick), 32'h0);
    chk("rm_square", 32'(square), 32'h0);
    chk("rm_pending", 32'(pending), 32'h0);
    reset = 1'b0;
    tick_n(0, 100, n);        chk("rm_first_tick", 32'(n), 32'd50);
    chk("rm_all_tick", 32'(tick), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
